uart_tx: RTL and testbench

// - UART transmitter; upstream counterpart of the UART receiver, driving the serial line it samples.
// - Accepts one byte per valid/ready handshake and serialises it as a frame:

---
 rtl/uart_tx.sv | 112 +++++++++++
 tb/tb_uart_tx.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, one byte per valid/ready handshake, start + 8 data bits MSB-first + [even parity] + stop bit(s).
// Ports: SampleClk oversample clock; Reset sync active-high; TxValid/TxData/TxReady byte handshake;
//        SerialOut serial line (idles high); TxBusy frame in flight; TxDone one-cycle end-of-frame pulse.
// Params: OVERSAMPLE clocks per bit (2..256); STOP_BITS 1 or 2.
// Macro UART_TX_PARITY_EN: when defined, an even parity bit follows the data bits.
module uart_tx #(
   parameter int OVERSAMPLE = 16,
   parameter int STOP_BITS  = 1
) (
   input  logic       SampleClk,
   input  logic       Reset,
   input  logic       TxValid,
   input  logic [7:0] TxData,
   output logic       TxReady,
   output logic       SerialOut,
   output logic       TxBusy,
   output logic       TxDone
);
   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t        state;
   logic [CW-1:0] sample_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
`ifdef UART_TX_PARITY_EN
   logic          par;
`endif
   always_ff @(posedge SampleClk) begin
      if (Reset) begin
         state      <= IDLE;
         sample_cnt <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         TxReady    <= 1'b1;
         SerialOut  <= 1'b1;
         TxBusy     <= 1'b0;
         TxDone     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par        <= 1'b0;
`endif
      end else begin
         TxDone <= 1'b0;
         if (state == IDLE) begin
            if (TxValid && TxReady) begin
               state      <= START;
               shreg      <= TxData;
               sample_cnt <= '0;
               bit_cnt    <= '0;
               TxReady    <= 1'b0;
               TxBusy     <= 1'b1;
               SerialOut  <= 1'b0;
`ifdef UART_TX_PARITY_EN
               par        <= ^TxData;
`endif
            end
         end else if (sample_cnt != LAST) begin
            sample_cnt <= sample_cnt + 1'b1;
         end else begin
            // bit period ends: register the next bit's value onto the line
            sample_cnt <= '0;
            case (state)
               START: begin
                  state     <= DATA;
                  bit_cnt   <= '0;
                  SerialOut <= shreg[7];
                  shreg     <= {shreg[6:0], 1'b0};
               end
               DATA: begin
                  if (bit_cnt == 3'd7) begin
                     bit_cnt   <= '0;
`ifdef UART_TX_PARITY_EN
                     state     <= PARITY;
                     SerialOut <= par;
`else
                     state     <= STOP;
                     SerialOut <= 1'b1;
`endif
                  end else begin
                     bit_cnt   <= bit_cnt + 1'b1;
                     SerialOut <= shreg[7];
                     shreg     <= {shreg[6:0], 1'b0};
                  end
               end
               PARITY: begin
                  state     <= STOP;
                  bit_cnt   <= '0;
                  SerialOut <= 1'b1;
               end
               STOP: begin
                  // bit_cnt counts stop-bit periods
                  if (bit_cnt == 3'(STOP_BITS - 1)) begin
                     state   <= IDLE;
                     bit_cnt <= '0;
                     TxReady <= 1'b1;
                     TxBusy  <= 1'b0;
                     TxDone  <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               default: begin
                  state     <= IDLE;
                  TxReady   <= 1'b1;
                  TxBusy    <= 1'b0;
                  SerialOut <= 1'b1;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx (16x/1-stop and 4x/2-stop instances), vector table plus random bytes.
module tb_uart_tx;
`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   typedef struct {
      logic [7:0] data;
      logic       par;
   } vec_t;
   logic       clk = 1'b0;
   logic       rst;
   logic       valid;
   logic [7:0] data;
   logic       sel = 1'b0;
   logic       ready1, so1, busy1, done1;
   logic       ready2, so2, busy2, done2;
   wire        ready = sel ? ready2 : ready1;
   wire        so    = sel ? so2 : so1;
   wire        busy  = sel ? busy2 : busy1;
   wire        done  = sel ? done2 : done1;
   int         chk_cnt = 0;
   int         pass_cnt = 0;
   vec_t       vecs[12];
   always #5 clk = ~clk;
   uart_tx #(.OVERSAMPLE(16), .STOP_BITS(1)) dut (
      .SampleClk(clk), .Reset(rst), .TxValid(valid && !sel), .TxData(data),
      .TxReady(ready1), .SerialOut(so1), .TxBusy(busy1), .TxDone(done1)
   );
   uart_tx #(.OVERSAMPLE(4), .STOP_BITS(2)) dut2 (
      .SampleClk(clk), .Reset(rst), .TxValid(valid && sel), .TxData(data),
      .TxReady(ready2), .SerialOut(so2), .TxBusy(busy2), .TxDone(done2)
   );
   task automatic chk(input string nm, input logic act, input logic exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
   endtask
   // reference frame: start 0, data MSB first, optional even parity, then stop ones
   function automatic logic exp_bit(input logic [7:0] d, input logic p, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return d[8 - idx];
      if (P == 1 && idx == 9) return p;
      return 1'b1;
   endfunction
   task automatic idle(input int n, input string nm);
      repeat (n) begin
         @(negedge clk);
         chk({nm, " idle line"}, so, 1'b1);
         chk({nm, " idle busy"}, busy, 1'b0);
         chk({nm, " idle done"}, done, 1'b0);
         chk({nm, " idle ready"}, ready, 1'b1);
      end
   endtask
   // drives one accept; returns at the negedge just after the accept edge
   task automatic start(input logic [7:0] d, input logic hold, input string nm);
      chk({nm, " ready before accept"}, ready, 1'b1);
      valid = 1'b1;
      data  = d;
      @(negedge clk);
      data = ~d;
      if (!hold) valid = 1'b0;
   endtask
   // checks every cycle of the frame, ends at the negedge after the final stop edge
   task automatic run_frame(input logic [7:0] d, input logic p, input int os, input int sb, input string nm);
      int f;
      f = (9 + P + sb) * os;
      for (int k = 0; k < f; k++) begin
         chk({nm, " line"}, so, exp_bit(d, p, k / os));
         chk({nm, " busy"}, busy, 1'b1);
         chk({nm, " done"}, done, 1'b0);
         chk({nm, " ready"}, ready, 1'b0);
         @(negedge clk);
      end
      chk({nm, " end done"}, done, 1'b1);
      chk({nm, " end busy"}, busy, 1'b0);
      chk({nm, " end ready"}, ready, 1'b1);
      chk({nm, " end line"}, so, 1'b1);
   endtask
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      logic [7:0] r;
      vecs[0]  = '{8'hA5, 1'b0};
      vecs[1]  = '{8'h00, 1'b0};
      vecs[2]  = '{8'hFF, 1'b0};
      vecs[3]  = '{8'h81, 1'b0};
      vecs[4]  = '{8'h55, 1'b0};
      vecs[5]  = '{8'hF0, 1'b0};
      vecs[6]  = '{8'hC3, 1'b0};
      vecs[7]  = '{8'h01, 1'b1};
      vecs[8]  = '{8'h80, 1'b1};
      vecs[9]  = '{8'h7F, 1'b1};
      vecs[10] = '{8'h3C, 1'b0};
      vecs[11] = '{8'h0E, 1'b1};
      rst   = 1'b1;
      valid = 1'b1;
      data  = 8'h5A;
      repeat (3) begin
         @(negedge clk);
         chk("reset line", so, 1'b1);
         chk("reset ready", ready, 1'b1);
         chk("reset busy", busy, 1'b0);
         chk("reset done", done, 1'b0);
      end
      rst   = 1'b0;
      valid = 1'b0;
      idle(3, "post reset");
      for (int i = 0; i < 12; i++) begin
         start(vecs[i].data, 1'b0, "vec");
         run_frame(vecs[i].data, vecs[i].par, 16, 1, "vec");
         idle(2, "vec");
      end
      for (int i = 0; i < 12; i++) begin
         r = 8'($urandom);
         start(r, 1'b0, "rand");
         run_frame(r, 1'($countones(r) % 2), 16, 1, "rand");
         idle(1 + int'($urandom_range(0, 3)), "rand");
      end
      start(8'h00, 1'b1, "b2b");
      data = 8'hFF;
      run_frame(8'h00, 1'b0, 16, 1, "b2b first");
      @(negedge clk);
      valid = 1'b0;
      data  = 8'h12;
      run_frame(8'hFF, 1'b0, 16, 1, "b2b second");
      idle(3, "b2b");
      start(8'h81, 1'b0, "busy ign");
      fork
         run_frame(8'h81, 1'b0, 16, 1, "busy ign");
         begin
            repeat (40) @(negedge clk);
            valid = 1'b1;
            data  = 8'h3C;
            @(negedge clk);
            valid = 1'b0;
         end
      join
      idle(20, "busy ign");
      start(8'hF0, 1'b0, "rst mid");
      repeat (5 * 16 + 8) @(negedge clk);
      chk("rst mid bit4 line", so, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst mid line", so, 1'b1);
      chk("rst mid busy", busy, 1'b0);
      chk("rst mid done", done, 1'b0);
      chk("rst mid ready", ready, 1'b1);
      idle(200, "rst mid");
      start(8'h55, 1'b0, "after rst");
      run_frame(8'h55, 1'b0, 16, 1, "after rst");
      idle(2, "after rst");
      sel = 1'b1;
      idle(2, "os4");
      start(8'hC3, 1'b0, "os4 sb2");
      run_frame(8'hC3, 1'b0, 4, 2, "os4 sb2");
      idle(2, "os4");
      for (int i = 0; i < 4; i++) begin
         r = 8'($urandom);
         start(r, 1'b0, "os4 rand");
         run_frame(r, 1'($countones(r) % 2), 4, 2, "os4 rand");
         idle(1, "os4 rand");
      end
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
